// File: rtl/regfile_wb_scheduler_pkg.sv
// rtl/regfile_wb_scheduler_pkg.sv - shared register-index and writeback-source definitions
package regfile_wb_scheduler_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  // Writeback requester encoding, also used by pipeline control
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_scheduler_wb_arbiter.sv
// rtl/regfile_wb_scheduler_wb_arbiter.sv - LSU-first write-port arbiter with ALU starvation bound
module wb_arbiter
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    alu_valid,
  input  logic    lsu_valid,
  output logic    alu_ready,
  output logic    lsu_ready,
  output logic    grant_valid,
  output wb_src_e grant_src
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             alu_forced;

  assign alu_forced = (starve_cnt >= LIMIT);

  // LSU wins by default; an ALU starved for LIMIT cycles takes the port
  always_comb begin
    alu_ready = alu_valid && (!lsu_valid || alu_forced);
    lsu_ready = lsu_valid && !alu_ready;
    grant_valid = alu_ready || lsu_ready;
    grant_src = alu_ready ? WB_SRC_ALU : WB_SRC_LSU;
  end

  // Count consecutive cycles the ALU waits; any grant or idle cycle restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (alu_valid && !alu_ready) begin
      if (starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register-file write-port scheduler and busy scoreboard
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rs1,
  input  logic [REG_IDX_W-1:0] issue_rs2,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 issue_writes,
  output logic                 issue_stall,
  input  logic                 alu_wb_valid,
  input  logic [REG_IDX_W-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]      alu_wb_val,
  output logic                 alu_wb_ready,
  input  logic                 lsu_wb_valid,
  input  logic [REG_IDX_W-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]      lsu_wb_val,
  output logic                 lsu_wb_ready,
  output logic                 write_rd,
  output logic [REG_IDX_W-1:0] rd,
  output logic [XLEN-1:0]      rd_val,
  output logic [5:0]           busy_count,
  output logic                 sb_error
);

  logic [RLEN-1:0]      busy;
  logic [RLEN-1:0]      busy_nxt;
  logic                 flush_d;
  logic                 grant_valid;
  wb_src_e              grant_src;
  logic [REG_IDX_W-1:0] g_rd;
  logic [XLEN-1:0]      g_val;
  logic                 issue_fire;
  logic                 err_hit;

  function automatic logic [5:0] popcount(input logic [RLEN-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < RLEN; i++) begin
      n = n + {5'b0, v[i]};
    end
    return n;
  endfunction

  wb_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_wb_valid),
    .lsu_valid  (lsu_wb_valid),
    .alu_ready  (alu_wb_ready),
    .lsu_ready  (lsu_wb_ready),
    .grant_valid(grant_valid),
    .grant_src  (grant_src)
  );

  // Steer the granted request onto the write port; x0 writes are swallowed
  always_comb begin
    g_rd  = REG_ZERO;
    g_val = '0;
    if (grant_valid) begin
      g_rd  = (grant_src == WB_SRC_ALU) ? alu_wb_rd  : lsu_wb_rd;
      g_val = (grant_src == WB_SRC_ALU) ? alu_wb_val : lsu_wb_val;
    end
    write_rd = grant_valid && (g_rd != REG_ZERO);
    rd       = g_rd;
    rd_val   = g_val;
  end

  // Hazard check against the registered scoreboard only (no same-cycle bypass)
  always_comb begin
    issue_stall = issue_valid &&
                  (busy[issue_rs1] || busy[issue_rs2] ||
                   (issue_writes && busy[issue_rd]) || flush);
    issue_fire  = issue_valid && !issue_stall;
    err_hit     = write_rd && !busy[g_rd] && !flush && !flush_d;
  end

  // Next scoreboard: flush wipes everything, else clear on writeback then set on issue
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (write_rd) begin
        busy_nxt[g_rd] = 1'b0;
      end
      if (issue_fire && issue_writes && (issue_rd != REG_ZERO)) begin
        busy_nxt[issue_rd] = 1'b1;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard state, its population count, flush history and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
      flush_d    <= 1'b0;
      sb_error   <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= popcount(busy_nxt);
      flush_d    <= flush;
      if (err_hit) begin
        sb_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - self-checking bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;

  localparam int XLEN = 32;
  localparam int RLEN = 32;
  localparam int STARVE_LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            issue_valid;
  logic [4:0]      issue_rs1, issue_rs2, issue_rd;
  logic            issue_writes;
  logic            issue_stall;
  logic            alu_wb_valid;
  logic [4:0]      alu_wb_rd;
  logic [XLEN-1:0] alu_wb_val;
  logic            alu_wb_ready;
  logic            lsu_wb_valid;
  logic [4:0]      lsu_wb_rd;
  logic [XLEN-1:0] lsu_wb_val;
  logic            lsu_wb_ready;
  logic            write_rd;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_val;
  logic [5:0]      busy_count;
  logic            sb_error;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(
    .XLEN(XLEN), .RLEN(RLEN), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_writes(issue_writes), .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_val(alu_wb_val),
    .alu_wb_ready(alu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_val(lsu_wb_val),
    .lsu_wb_ready(lsu_wb_ready),
    .write_rd(write_rd), .rd(rd), .rd_val(rd_val),
    .busy_count(busy_count), .sb_error(sb_error)
  );

  int n_checks = 0;
  int n_pass = 0;

  // reference model state
  bit m_busy[32];
  int m_starve;
  bit m_err;
  bit m_flush_d;
  bit m_alu_hold;
  bit m_lsu_hold;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit mb(input logic [4:0] r);
    return (r != 0) && m_busy[r];
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 1; i < 32; i++) n += m_busy[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_starve = 0;
    m_err = 0;
    m_flush_d = 0;
    m_alu_hold = 0;
    m_lsu_hold = 0;
  endtask

  // who owns the port this cycle, what it writes, and whether issue stalls
  task automatic model_eval(output bit aw, output bit lw, output logic [4:0] g_rd,
                            output logic [XLEN-1:0] g_val, output bit stall);
    aw = alu_wb_valid && (!lsu_wb_valid || m_starve >= STARVE_LIMIT);
    lw = lsu_wb_valid && !aw;
    g_rd = aw ? alu_wb_rd : (lw ? lsu_wb_rd : 5'd0);
    g_val = aw ? alu_wb_val : (lw ? lsu_wb_val : '0);
    stall = issue_valid && (mb(issue_rs1) || mb(issue_rs2) ||
            (issue_writes && mb(issue_rd)) || flush);
  endtask

  task automatic model_check();
    bit aw, lw, stall;
    logic [4:0] g_rd;
    logic [XLEN-1:0] g_val;
    model_eval(aw, lw, g_rd, g_val, stall);
    check("alu_ready", 64'(alu_wb_ready), 64'(aw));
    check("lsu_ready", 64'(lsu_wb_ready), 64'(lw));
    check("write_rd", 64'(write_rd), 64'((aw || lw) && g_rd != 0));
    check("rd", 64'(rd), 64'(g_rd));
    check("rd_val", 64'(rd_val), 64'(g_val));
    check("issue_stall", 64'(issue_stall), 64'(stall));
    check("busy_count", 64'(busy_count), 64'(model_count()));
    check("sb_error", 64'(sb_error), 64'(m_err));
  endtask

  task automatic model_update();
    bit aw, lw, stall;
    logic [4:0] g_rd;
    logic [XLEN-1:0] g_val;
    model_eval(aw, lw, g_rd, g_val, stall);
    if ((aw || lw) && g_rd != 0 && !m_busy[g_rd] && !flush && !m_flush_d) m_err = 1;
    if (alu_wb_valid && !aw) m_starve++;
    else m_starve = 0;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else begin
      if ((aw || lw) && g_rd != 0) m_busy[g_rd] = 0;
      if (issue_valid && !stall && issue_writes && issue_rd != 0) m_busy[issue_rd] = 1;
    end
    m_flush_d = flush;
    m_alu_hold = alu_wb_valid && !aw;
    m_lsu_hold = lsu_wb_valid && !lw;
  endtask

  // check everything mid-cycle, then advance DUT and model together
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    flush = 0;
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_writes = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_val = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_val = 0;
  endtask

  task automatic do_issue(input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] d, input logic w);
    issue_valid = 1; issue_rs1 = r1; issue_rs2 = r2; issue_rd = d; issue_writes = w;
  endtask

  function automatic logic [4:0] pick_rd();
    int q[$];
    for (int i = 1; i < 8; i++) if (m_busy[i]) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 9) < 8) return 5'(q[$urandom_range(0, q.size() - 1)]);
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    model_reset();
    rst = 1;
    @(posedge clk); #1;
    check("reset_busy_count", 64'(busy_count), 64'd0);
    check("reset_sb_error", 64'(sb_error), 64'd0);
    rst = 0;

    // issue rd=5, then ALU writeback while a dependent waits
    do_issue(0, 0, 5, 1);
    step();
    idle();
    check("t1_count_after_issue", 64'(busy_count), 64'd1);
    do_issue(5, 0, 0, 0);
    alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_val = 32'hDEAD;
    #1;
    check("t1_write_rd", 64'(write_rd), 64'd1);
    check("t1_rd", 64'(rd), 64'd5);
    check("t1_rd_val", 64'(rd_val), 64'hDEAD);
    check("t1_stall_in_wb", 64'(issue_stall), 64'd1);
    step();
    alu_wb_valid = 0;
    #1;
    check("t1_count_after_wb", 64'(busy_count), 64'd0);
    check("t1_stall_clear", 64'(issue_stall), 64'd0);
    step();
    idle();

    // continuous contention: LSU x4, ALU, repeat
    alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_val = 32'h1;
    lsu_wb_valid = 1; lsu_wb_rd = 0; lsu_wb_val = 32'h2;
    for (int i = 0; i < 14; i++) begin
      #1;
      check($sformatf("t2_alu_grant_%0d", i), 64'(alu_wb_ready), 64'(i % 5 == 4));
      step();
    end
    idle();
    step();

    // WAW on x3
    do_issue(0, 0, 3, 1);
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t3_waw_stall", 64'(issue_stall), 64'd1);
      step();
    end
    alu_wb_valid = 1; alu_wb_rd = 3; alu_wb_val = 32'h33;
    #1;
    check("t3_stall_in_wb", 64'(issue_stall), 64'd1);
    step();
    alu_wb_valid = 0;
    #1;
    check("t3_fires", 64'(issue_stall), 64'd0);
    step();
    idle();
    check("t3_reset_busy", 64'(busy_count), 64'd1);
    alu_wb_valid = 1; alu_wb_rd = 3;
    step();
    idle();

    // LSU write to x0
    lsu_wb_valid = 1; lsu_wb_rd = 0; lsu_wb_val = 32'h1234;
    #1;
    check("t4_lsu_ready", 64'(lsu_wb_ready), 64'd1);
    check("t4_write_rd", 64'(write_rd), 64'd0);
    step();
    idle();
    check("t4_count", 64'(busy_count), 64'd0);
    check("t4_err", 64'(sb_error), 64'd0);

    // flush with three registers busy
    for (int r = 7; r <= 9; r++) begin
      do_issue(0, 0, 5'(r), 1);
      step();
    end
    idle();
    check("t5_three_busy", 64'(busy_count), 64'd3);
    flush = 1;
    do_issue(0, 0, 10, 1);
    #1;
    check("t5_flush_stall", 64'(issue_stall), 64'd1);
    step();
    idle();
    check("t5_count_flushed", 64'(busy_count), 64'd0);
    alu_wb_valid = 1; alu_wb_rd = 7; alu_wb_val = 32'h77;
    #1;
    check("t5_post_flush_write", 64'(write_rd), 64'd1);
    step();
    check("t5_post_flush_noerr", 64'(sb_error), 64'd0);
    alu_wb_rd = 8;
    step();
    idle();
    check("t5_stray_err", 64'(sb_error), 64'd1);

    // asynchronous reset mid-stream
    do_issue(0, 0, 4, 1); step();
    do_issue(0, 0, 6, 1); step();
    idle();
    alu_wb_valid = 1; lsu_wb_valid = 1;
    for (int i = 0; i < 3; i++) step();
    check("t6_two_busy", 64'(busy_count), 64'd2);
    rst = 1;
    #1;
    check("t6_rst_count", 64'(busy_count), 64'd0);
    check("t6_rst_err", 64'(sb_error), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("t6_post_rst_lsu", 64'(lsu_wb_ready), 64'd1);
    check("t6_post_rst_alu", 64'(alu_wb_ready), 64'd0);
    step();
    idle();
    step();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_rs1 = 5'($urandom_range(0, 7));
      issue_rs2 = 5'($urandom_range(0, 7));
      issue_rd = 5'($urandom_range(0, 7));
      issue_writes = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 29) == 0);
      if (!m_alu_hold) begin
        alu_wb_valid = 1'($urandom_range(0, 1));
        alu_wb_rd = pick_rd();
        alu_wb_val = $urandom;
      end
      if (!m_lsu_hold) begin
        lsu_wb_valid = 1'($urandom_range(0, 1));
        lsu_wb_rd = pick_rd();
        lsu_wb_val = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
